dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data_memory port between two requesters.
//  - Port m0: the riscv core load/store path.
//  - Port m1: a loader/DMA master.
//  Arbitrates with 2-way round-robin, sequences exactly one memory strobe per transaction,
//  registers read data and returns a one-cycle response pulse.
//  Rejects misaligned, out-of-range and illegal-type accesses without touching memory.
// PARAMETERS
//  ADDR_W     32            address width
//  DATA_W     32            data width
//  ADDR_LIMIT 32'h0000_03FF highest legal byte address; any accessed byte above it -> error
// PORTS
//  clk          in   1       single clock
//  rst          in   1       one clock; reset is synchronous and active-high
//  mN_req       in   1       N=0,1: request; held with fields stable until mN_gnt
//  mN_we        in   1       1=store, 0=load
//  mN_addr      in   ADDR_W  byte address
//  mN_type      in   3       rw_type, funct3 coding: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  mN_wdata     in   DATA_W  store data, LSB-aligned
//  mN_gnt       out  1       1-cycle pulse: request sampled this cycle
//  mN_rvalid    out  1       1-cycle response pulse; also sent for stores (ack)
//  mN_rdata     out  DATA_W  load data; valid only with mN_rvalid
//  mN_err       out  1       with mN_rvalid: access rejected, no strobe issued
//  mem_w_en     out  1       to data_memory w_en
//  mem_r_en     out  1       to data_memory r_en
//  mem_addr     out  ADDR_W  to data_memory addr
//  mem_rw_type  out  3       to data_memory rw_type
//  mem_din      out  DATA_W  to data_memory din
//  mem_dout     in   DATA_W  from data_memory dout; combinational read
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  Reset values: all outputs 0; state=IDLE; last_owner=1, so m0 wins first contention.
//  FSM states: IDLE, ISSUE, RESP.
//  - IDLE: if any req -> pick owner, pulse owner gnt, latch we/addr/type/wdata, compute err -> ISSUE.
//  - ISSUE: if !err, drive mem_r_en=!we or mem_w_en=we for exactly this cycle from latched fields.
//    Capture mem_dout into rdata reg at the clock edge (loads only) -> RESP.
//    If err, no strobe is driven and mem_* hold 0.
//  - RESP: pulse owner rvalid, with err flag and rdata.
//    The same cycle re-arbitrates like IDLE: a pending req is granted -> ISSUE, else -> IDLE.
//  Latency: gnt at T, strobe at T+1, rvalid at T+2; back-to-back throughput 1 access / 2 cycles.
//  Round-robin: with both req, grant !last_owner; last_owner updates on every gnt.
//  A lone requester is always granted, with no idle bubble.
//  Errors:
//  - type in {011,110,111} -> err.
//  - H/HU with addr[0]!=0 -> err; W with addr[1:0]!=0 -> err.
//  - addr + size - 1 > ADDR_LIMIT -> err; compute in ADDR_W+1 bits so there is no wrap at 0xFFFF_FFFF.
//  rdata: mem_dout passed unmodified; data_memory performs extend/merge.
//  mN_rdata is 0 for stores and errors.
//  gnt and rvalid go only to the owner; the other port outputs stay 0.
//  req dropped before gnt: withdrawn, no effect. req held after gnt: treated as a new request.
//  Reset mid-transaction: the transaction is abandoned.
//  No strobe and no rvalid are emitted after rst is seen; FSM returns to IDLE next cycle.
// STRUCTURE
//  Shared header riscv_defines.vh holds:
//  - rw_type codes (RW_B, RW_H, RW_W, RW_BU, RW_HU)
//  - FSM state encodings (ARB_IDLE/ISSUE/RESP)
//  Sub-module rr_arb2: combinational 2-way round-robin picker.
//  - Inputs: req[1:0], last_owner. Outputs: grant onehot, owner.
//  - FSM, latches and error check stay in dmem_arbiter.
// TESTING
//  1. Core load: m0 LW addr 0x10, mem_dout=0xDEADBEEF -> m0_gnt@T, mem_r_en@T+1 addr 0x10,
//     m0_rvalid@T+2 rdata 0xDEADBEEF, err=0.
//  2. Contention: m0,m1 both req stores from reset -> grant order m0,m1,m0,m1.
//     Each port sees 1 mem_w_en per grant; strobes 2 cycles apart.
//  3. Misaligned: m1 SH addr 0x3 and LW addr 0x2 -> m1_rvalid with err=1;
//     mem_w_en/mem_r_en never asserted.
//  4. Range/type: LW addr 0x3FC ok; LW addr 0x3FE err; LH 0x3FE ok; type 3'b011 err;
//     addr 0xFFFF_FFFC err (no wrap).
//  5. Reset in ISSUE: assert rst at T+1 -> no rvalid ever for that access.
//     Outputs 0 next cycle; first grant after reset goes to m0.
//  6. Back-to-back: m0 holds req for 4 transactions -> gnt every 2 cycles;
//     rvalid count = 4; busy stays 1 until the last RESP.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: rw_type codes, FSM states
// and the access-size helper used by the range check.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_e;

  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  // Bytes touched by an access; 0 marks an illegal type.
  function automatic logic [2:0] rw_size(input logic [2:0] t);
    logic [2:0] s;
    case (t)
      RW_B, RW_BU: s = 3'd1;
      RW_H, RW_HU: s = 3'd2;
      RW_W:        s = 3'd4;
      default:     s = 3'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker: a lone requester always wins,
// contention goes to the port that did not own the last grant.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] grant,
  output logic       owner
);

  always_comb begin
    owner = 1'b0;
    if (req[0] && req[1]) owner = ~last_owner;
    else                  owner = req[1];
    grant = {owner, ~owner} & {2{|req}};
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data_memory port between the core (m0) and a loader/DMA (m1):
// grant, one strobe, registered response; rejected accesses never touch memory.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = 32'h0000_03FF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [2:0]        m0_type,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [2:0]        m1_type,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_w_en,
  output logic              mem_r_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_rw_type,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  localparam int AW1 = ADDR_W + 1;

  // Last byte is computed one bit wider so an access near the top of the
  // address space cannot wrap back under the limit.
  function automatic logic access_err(input logic [2:0] t, input logic [ADDR_W-1:0] a);
    logic           misaligned;
    logic [AW1-1:0] last_byte;
    misaligned = 1'b0;
    case (t)
      RW_B, RW_BU: misaligned = 1'b0;
      RW_H, RW_HU: misaligned = a[0];
      RW_W:        misaligned = |a[1:0];
      default:     misaligned = 1'b1;
    endcase
    last_byte = {1'b0, a} + AW1'(rw_size(t)) - AW1'(1);
    return misaligned || (last_byte > {1'b0, ADDR_LIMIT});
  endfunction

  arb_state_e        state, state_d;
  logic              last_owner;
  logic [1:0]        grant;
  logic              pick_owner;
  logic              accept;

  logic              owner_p1;
  logic              we_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [2:0]        type_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic              err_p1;
  logic [DATA_W-1:0] rdata_p2;

  logic              strobe;
  logic              resp;

  rr_arb2 u_rr (
    .req        ({m1_req, m0_req}),
    .last_owner (last_owner),
    .grant      (grant),
    .owner      (pick_owner)
  );

  always_comb begin
    accept  = !rst && (m0_req || m1_req) &&
              (state == ARB_IDLE || state == ARB_RESP);
    state_d = state;
    case (state)
      ARB_IDLE:  state_d = accept ? ARB_ISSUE : ARB_IDLE;
      ARB_ISSUE: state_d = ARB_RESP;
      ARB_RESP:  state_d = accept ? ARB_ISSUE : ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      last_owner <= 1'b1;
      owner_p1   <= 1'b0;
      err_p1     <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        last_owner <= pick_owner;
        owner_p1   <= pick_owner;
        err_p1     <= pick_owner ? access_err(m1_type, m1_addr)
                                 : access_err(m0_type, m0_addr);
      end
    end
  end

  // ---- grant -> issue: latch the winner's request fields
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p1    <= pick_owner ? m1_we    : m0_we;
      addr_p1  <= pick_owner ? m1_addr  : m0_addr;
      type_p1  <= pick_owner ? m1_type  : m0_type;
      wdata_p1 <= pick_owner ? m1_wdata : m0_wdata;
    end
  end

  // ---- issue -> resp: capture load data; stores and errors return zero
  always_ff @(posedge clk) begin
    if (state == ARB_ISSUE)
      rdata_p2 <= (!we_p1 && !err_p1) ? mem_dout : '0;
  end

  always_comb begin
    strobe      = !rst && (state == ARB_ISSUE) && !err_p1;
    resp        = !rst && (state == ARB_RESP);
    mem_r_en    = strobe && !we_p1;
    mem_w_en    = strobe && we_p1;
    mem_addr    = strobe ? addr_p1  : '0;
    mem_rw_type = strobe ? type_p1  : 3'b000;
    mem_din     = strobe ? wdata_p1 : '0;
    m0_gnt      = accept && grant[0];
    m1_gnt      = accept && grant[1];
    m0_rvalid   = resp && !owner_p1;
    m1_rvalid   = resp && owner_p1;
    m0_err      = m0_rvalid && err_p1;
    m1_err      = m1_rvalid && err_p1;
    m0_rdata    = m0_rvalid ? rdata_p2 : '0;
    m1_rdata    = m1_rvalid ? rdata_p2 : '0;
    busy        = !rst && (state != ARB_IDLE);
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: latency, round-robin order, error
// rejection, reset abandonment and back-to-back throughput.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [2:0]  m0_type, m1_type;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_w_en, mem_r_en, busy;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic [2:0]  mem_rw_type;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_type(m0_type),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_type(m1_type),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_w_en(mem_w_en), .mem_r_en(mem_r_en), .mem_addr(mem_addr),
    .mem_rw_type(mem_rw_type), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy)
  );

  task automatic do_reset();
    m0_req = 0; m1_req = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drives one transaction on a port and records what the DUT did with it.
  task automatic drive_txn(input bit port, input bit we, input logic [31:0] addr,
                           input logic [2:0] typ, input logic [31:0] wdata,
                           input logic [31:0] dout, output bit got_gnt,
                           output int n_strobe, output bit got_rv, output bit err,
                           output logic [31:0] rdata, output int rv_lat);
    int gk;
    gk = -1; got_gnt = 0; n_strobe = 0; got_rv = 0; err = 0; rdata = '0; rv_lat = -1;
    mem_dout = dout;
    if (port) begin
      m1_we = we; m1_addr = addr; m1_type = typ; m1_wdata = wdata; m1_req = 1'b1;
    end else begin
      m0_we = we; m0_addr = addr; m0_type = typ; m0_wdata = wdata; m0_req = 1'b1;
    end
    for (int k = 0; k < 6; k++) begin
      #1;
      if ((port ? m1_gnt : m0_gnt) && gk < 0) begin gk = k; got_gnt = 1; end
      if (mem_r_en || mem_w_en) n_strobe++;
      if (port ? m1_rvalid : m0_rvalid) begin
        got_rv = 1;
        err    = port ? m1_err : m0_err;
        rdata  = port ? m1_rdata : m0_rdata;
        rv_lat = k - gk;
      end
      @(posedge clk); #1;
      if (gk >= 0) begin m0_req = 0; m1_req = 0; end
    end
  endtask

  task automatic test_reset();
    m0_req = 1'b1; m0_we = 0; m0_addr = 32'h10; m0_type = 3'b010; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_type = 3'b010; m1_wdata = 0;
    mem_dout = 32'h1234_5678;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if ({m0_gnt, m1_gnt, mem_r_en, mem_w_en, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_hold: gnt0/gnt1/ren/wen/busy=%b want 00000",
               {m0_gnt, m1_gnt, mem_r_en, mem_w_en, busy});
    end
    m0_req = 0;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, mem_w_en, mem_r_en, busy} !== 9'b0 ||
        mem_addr !== 0 || mem_din !== 0 || mem_rw_type !== 0 || m0_rdata !== 0 || m1_rdata !== 0) begin
      n_fail++;
      $display("FAIL reset_values: ctl=%b addr=%h din=%h rd0=%h rd1=%h want all 0",
               {m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, mem_w_en, mem_r_en, busy},
               mem_addr, mem_din, m0_rdata, m1_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_core_load();
    m0_we = 0; m0_addr = 32'h10; m0_type = 3'b010; m0_req = 1'b1;
    mem_dout = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL load_gnt: gnt0=%b gnt1=%b busy=%b want 1 0 0", m0_gnt, m1_gnt, busy);
    end
    @(posedge clk); #1;
    m0_req = 0; #1;
    n_checks++;
    if (mem_r_en !== 1 || mem_w_en !== 0 || mem_addr !== 32'h10 || mem_rw_type !== 3'b010 ||
        m0_gnt !== 0 || busy !== 1) begin
      n_fail++;
      $display("FAIL load_strobe: ren=%b wen=%b addr=%h type=%b gnt0=%b busy=%b want 1 0 10 010 0 1",
               mem_r_en, mem_w_en, mem_addr, mem_rw_type, m0_gnt, busy);
    end
    @(posedge clk); #1;
    mem_dout = 32'h0; #1;
    n_checks++;
    if (m0_rvalid !== 1 || m0_rdata !== 32'hDEAD_BEEF || m0_err !== 0 || m1_rvalid !== 0 ||
        mem_r_en !== 0) begin
      n_fail++;
      $display("FAIL load_resp: rv0=%b rdata=%h err=%b rv1=%b ren=%b want 1 deadbeef 0 0 0",
               m0_rvalid, m0_rdata, m0_err, m1_rvalid, mem_r_en);
    end
    @(posedge clk); #1; #1;
    n_checks++;
    if (busy !== 0 || m0_rvalid !== 0 || m0_rdata !== 0) begin
      n_fail++;
      $display("FAIL load_idle: busy=%b rv0=%b rdata=%h want 0 0 0", busy, m0_rvalid, m0_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    logic [9:0]  g0, g1, w, r, v0, v1;
    logic [31:0] st_addr [4];
    logic [31:0] st_din  [4];
    logic [31:0] exp_addr [4];
    logic [31:0] exp_din  [4];
    int ns;
    g0 = 0; g1 = 0; w = 0; r = 0; v0 = 0; v1 = 0; ns = 0;
    exp_addr = '{32'h20, 32'h40, 32'h20, 32'h40};
    exp_din  = '{32'h1111_1111, 32'h2222_2222, 32'h1111_1111, 32'h2222_2222};
    do_reset();
    m0_we = 1; m0_addr = 32'h20; m0_type = 3'b010; m0_wdata = 32'h1111_1111;
    m1_we = 1; m1_addr = 32'h40; m1_type = 3'b010; m1_wdata = 32'h2222_2222;
    for (int c = 0; c < 10; c++) begin
      m0_req = (c < 7); m1_req = (c < 7);
      #1;
      g0[c] = m0_gnt; g1[c] = m1_gnt; w[c] = mem_w_en; r[c] = mem_r_en;
      v0[c] = m0_rvalid && !m0_err; v1[c] = m1_rvalid && !m1_err;
      if (mem_w_en && ns < 4) begin st_addr[ns] = mem_addr; st_din[ns] = mem_din; ns++; end
      @(posedge clk); #1;
    end
    n_checks++;
    if (g0 !== 10'h011 || g1 !== 10'h044) begin
      n_fail++;
      $display("FAIL rr_order: gnt0=%b gnt1=%b want 0000010001 0001000100", g0, g1);
    end
    n_checks++;
    if (w !== 10'h0AA || r !== 10'h000) begin
      n_fail++;
      $display("FAIL rr_strobes: wen=%b ren=%b want 0010101010 0000000000", w, r);
    end
    n_checks++;
    if (v0 !== 10'h044 || v1 !== 10'h110) begin
      n_fail++;
      $display("FAIL rr_acks: rv0=%b rv1=%b want 0001000100 0100010000", v0, v1);
    end
    n_checks++;
    if (ns != 4) begin
      n_fail++;
      $display("FAIL rr_strobe_count: got %0d want 4", ns);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (st_addr[k] !== exp_addr[k] || st_din[k] !== exp_din[k]) begin
          n_fail++;
          $display("FAIL rr_store[%0d]: addr=%h din=%h want %h %h",
                   k, st_addr[k], st_din[k], exp_addr[k], exp_din[k]);
        end
      end
    end
  endtask

  task automatic test_misaligned();
    bit g, rv, e; int ns, lat; logic [31:0] rd;
    drive_txn(1, 1, 32'h3, 3'b001, 32'hABCD, 32'hFFFF_FFFF, g, ns, rv, e, rd, lat);
    n_checks++;
    if (!(g && ns == 0 && rv && e && rd === 0 && lat == 2)) begin
      n_fail++;
      $display("FAIL misalign_sh: gnt=%b strobes=%0d rv=%b err=%b rdata=%h lat=%0d want 1 0 1 1 0 2",
               g, ns, rv, e, rd, lat);
    end
    drive_txn(1, 0, 32'h2, 3'b010, 32'h0, 32'hFFFF_FFFF, g, ns, rv, e, rd, lat);
    n_checks++;
    if (!(g && ns == 0 && rv && e && rd === 0 && lat == 2)) begin
      n_fail++;
      $display("FAIL misalign_lw: gnt=%b strobes=%0d rv=%b err=%b rdata=%h lat=%0d want 1 0 1 1 0 2",
               g, ns, rv, e, rd, lat);
    end
  endtask

  task automatic test_range_type();
    logic [31:0] addrs [5];
    logic [2:0]  types [5];
    bit          errs  [5];
    bit g, rv, e; int ns, lat; logic [31:0] rd, dv;
    addrs = '{32'h3FC, 32'h3FE, 32'h3FE, 32'h0, 32'hFFFF_FFFC};
    types = '{3'b010, 3'b010, 3'b001, 3'b011, 3'b010};
    errs  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      dv = 32'h5A5A_0000 + i;
      drive_txn(0, 0, addrs[i], types[i], 32'h0, dv, g, ns, rv, e, rd, lat);
      n_checks++;
      if (!(g && rv && lat == 2 && e == errs[i] && ns == (errs[i] ? 0 : 1) &&
            rd === (errs[i] ? 32'h0 : dv))) begin
        n_fail++;
        $display("FAIL range[%0d]: gnt=%b rv=%b lat=%0d err=%b strobes=%0d rdata=%h want err=%b strobes=%0d rdata=%h",
                 i, g, rv, lat, e, ns, rd, errs[i], errs[i] ? 0 : 1, errs[i] ? 32'h0 : dv);
      end
    end
    drive_txn(1, 1, 32'h100, 3'b010, 32'hCAFE_F00D, 32'h7777_7777, g, ns, rv, e, rd, lat);
    n_checks++;
    if (!(g && rv && !e && ns == 1 && rd === 0 && lat == 2)) begin
      n_fail++;
      $display("FAIL store_ack: gnt=%b rv=%b err=%b strobes=%0d rdata=%h lat=%0d want 1 1 0 1 0 2",
               g, rv, e, ns, rd, lat);
    end
  endtask

  task automatic test_reset_in_issue();
    int rv_seen;
    rv_seen = 0;
    m0_we = 0; m0_addr = 32'h10; m0_type = 3'b010; m0_req = 1'b1;
    mem_dout = 32'h1357_9BDF;
    #1;
    n_checks++;
    if (m0_gnt !== 1) begin
      n_fail++;
      $display("FAIL rst_issue_gnt: gnt0=%b want 1", m0_gnt);
    end
    @(posedge clk); #1;
    m0_req = 0; rst = 1'b1; #1;
    n_checks++;
    if ({mem_r_en, mem_w_en, m0_rvalid, m1_rvalid, busy} !== 5'b0 || mem_addr !== 0) begin
      n_fail++;
      $display("FAIL rst_issue_strobe: ren/wen/rv0/rv1/busy=%b addr=%h want 00000 0",
               {mem_r_en, mem_w_en, m0_rvalid, m1_rvalid, busy}, mem_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (m0_rvalid || m1_rvalid || mem_r_en || busy) rv_seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (rv_seen != 0) begin
      n_fail++;
      $display("FAIL rst_issue_abandon: active cycles=%0d want 0", rv_seen);
    end
    m0_req = 1; m1_req = 1; m1_we = 0; m1_addr = 32'h8; m1_type = 3'b010;
    #1;
    n_checks++;
    if (m0_gnt !== 1 || m1_gnt !== 0) begin
      n_fail++;
      $display("FAIL rst_first_gnt: gnt0=%b gnt1=%b want 1 0", m0_gnt, m1_gnt);
    end
    @(posedge clk); #1;
    m0_req = 0; m1_req = 0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  g, v, b, r;
    int nv, bad_rd;
    g = 0; v = 0; b = 0; r = 0; nv = 0; bad_rd = 0;
    m0_we = 0; m0_addr = 32'h40; m0_type = 3'b010;
    for (int c = 0; c < 10; c++) begin
      m0_req   = (c < 7);
      mem_dout = 32'hA000_0000 | c;
      #1;
      g[c] = m0_gnt; v[c] = m0_rvalid; b[c] = busy; r[c] = mem_r_en;
      if (m0_rvalid) begin
        nv++;
        if (m0_rdata !== (32'hA000_0000 | (c - 1))) bad_rd++;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (g !== 10'h055 || r !== 10'h0AA) begin
      n_fail++;
      $display("FAIL b2b_gnt: gnt=%b ren=%b want 0001010101 0010101010", g, r);
    end
    n_checks++;
    if (v !== 10'h154 || nv != 4) begin
      n_fail++;
      $display("FAIL b2b_rvalid: rv=%b count=%0d want 0101010100 4", v, nv);
    end
    n_checks++;
    if (b !== 10'h1FE) begin
      n_fail++;
      $display("FAIL b2b_busy: busy=%b want 0111111110", b);
    end
    n_checks++;
    if (bad_rd != 0) begin
      n_fail++;
      $display("FAIL b2b_rdata: wrong rdata beats=%0d want 0", bad_rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_core_load();
    test_contention();
    test_misaligned();
    test_range_type();
    test_reset_in_issue();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
